// File: rtl/interrupt_controller_if.sv
// Core-side interrupt handshake bundle: INT/NMI/INTD toward the core, INA back.
// fsm_state mirrors the controller FSM so checkers can observe it.
interface interrupt_controller_if;
   logic       INT;
   logic       NMI;
   logic       INTD;
   logic       INA;
   logic [1:0] fsm_state;

   // Handshake: INT or NMI is the valid, held stable until the core returns INA
   // (ready) sampled high on a rising edge. That edge completes the transfer,
   // drops the request and starts the serial vector on INTD the next cycle.
   modport master (output INT, NMI, INTD, fsm_state, input INA);
   modport slave  (input INT, NMI, INTD, fsm_state, output INA);
endinterface

// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt requester with single-level NMI nesting and serial vector delivery.
// Optional feature macro ACK_TIMEOUT_EN: abandon an unacknowledged request after TIMEOUT cycles.
module interrupt_controller #(
   parameter int NUM_IRQ = 8,
   parameter int VEC_W   = 3,
   parameter int TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_IRQ-1:0]     irq,
   input  logic                   nmi_req,
   input  logic                   mask_we,
   input  logic [NUM_IRQ-1:0]     mask_in,
   input  logic                   eoi,
   interrupt_controller_if.master core,
   output logic                   busy,
   output logic                   ack_timeout
);
   localparam int CW = $clog2(VEC_W + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      SEND   = 2'd2,
      INSERV = 2'd3
   } state_t;

   state_t             state;
   logic [NUM_IRQ-1:0] irq_q;
   logic [NUM_IRQ-1:0] pend;
   logic [NUM_IRQ-1:0] mask;
   logic               nmi_q;
   logic               nmi_pend;
   logic               irq_act;
   logic               nmi_act;
   logic [VEC_W:0]     frame;
   logic [VEC_W:0]     shift;
   logic [CW-1:0]      bit_cnt;
   logic               int_r;
   logic               nmi_r;
   logic               intd_r;
   logic               busy_r;

   logic [NUM_IRQ-1:0] irq_edge;
   logic [NUM_IRQ-1:0] cand;
   logic [VEC_W-1:0]   cand_vec;
   logic               has_cand;
   logic               nmi_edge;
   logic [NUM_IRQ-1:0] irq_clr;
   logic               nmi_clr;

   assign irq_edge = irq & ~irq_q;
   assign nmi_edge = nmi_req & ~nmi_q;
   assign cand     = pend & ~mask;
   assign has_cand = |cand;

   // Scan from the top so the lowest set index is the last one written.
   always_comb begin
      cand_vec = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (cand[i]) cand_vec = VEC_W'(i);
      end
   end

   always_comb begin
      irq_clr = '0;
      nmi_clr = 1'b0;
      if (state == REQ && core.INA) begin
         if (frame[VEC_W]) nmi_clr = 1'b1;
         else              irq_clr[frame[VEC_W-1:0]] = 1'b1;
      end
   end

`ifdef ACK_TIMEOUT_EN
   localparam int TW = (TIMEOUT < 256) ? 8 : $clog2(TIMEOUT + 1);
   logic [TW-1:0] tcnt;
   logic          ack_to_r;
   assign ack_timeout = ack_to_r;
`else
   // No timeout hardware: the pulse can never occur.
   assign ack_timeout = (TIMEOUT < 0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         irq_q    <= '0;
         pend     <= '0;
         mask     <= '1;
         nmi_q    <= 1'b0;
         nmi_pend <= 1'b0;
         irq_act  <= 1'b0;
         nmi_act  <= 1'b0;
         frame    <= '0;
         shift    <= '0;
         bit_cnt  <= '0;
         int_r    <= 1'b0;
         nmi_r    <= 1'b0;
         intd_r   <= 1'b0;
         busy_r   <= 1'b0;
`ifdef ACK_TIMEOUT_EN
         tcnt     <= '0;
         ack_to_r <= 1'b0;
`endif
      end else begin
         irq_q    <= irq;
         nmi_q    <= nmi_req;
         // A fresh edge on the bit being serviced keeps it pending.
         pend     <= (pend & ~irq_clr) | irq_edge;
         nmi_pend <= (nmi_pend & ~nmi_clr) | nmi_edge;
         if (mask_we) mask <= mask_in;
`ifdef ACK_TIMEOUT_EN
         ack_to_r <= 1'b0;
         if (state != REQ) tcnt <= '0;
`endif
         case (state)
            IDLE: begin
               if (nmi_pend) begin
                  state  <= REQ;
                  frame  <= {1'b1, {VEC_W{1'b0}}};
                  nmi_r  <= 1'b1;
                  busy_r <= 1'b1;
               end else if (has_cand) begin
                  state  <= REQ;
                  frame  <= {1'b0, cand_vec};
                  int_r  <= 1'b1;
                  busy_r <= 1'b1;
               end
            end
            REQ: begin
               if (core.INA) begin
                  state   <= SEND;
                  int_r   <= 1'b0;
                  nmi_r   <= 1'b0;
                  intd_r  <= frame[VEC_W];
                  shift   <= {frame[VEC_W-1:0], 1'b0};
                  bit_cnt <= CW'(VEC_W);
                  if (frame[VEC_W]) nmi_act <= 1'b1;
                  else              irq_act <= 1'b1;
               end
`ifdef ACK_TIMEOUT_EN
               else if (tcnt == TW'(TIMEOUT - 1)) begin
                  state    <= IDLE;
                  int_r    <= 1'b0;
                  nmi_r    <= 1'b0;
                  busy_r   <= 1'b0;
                  ack_to_r <= 1'b1;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
`endif
            end
            SEND: begin
               if (bit_cnt == '0) begin
                  state  <= INSERV;
                  intd_r <= 1'b0;
               end else begin
                  intd_r  <= shift[VEC_W];
                  shift   <= {shift[VEC_W-1:0], 1'b0};
                  bit_cnt <= bit_cnt - CW'(1);
               end
            end
            INSERV: begin
               if (eoi) begin
                  if (nmi_act) begin
                     nmi_act <= 1'b0;
                     if (!irq_act) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                     end
                  end else begin
                     irq_act <= 1'b0;
                     state   <= IDLE;
                     busy_r  <= 1'b0;
                  end
               end else if (irq_act && !nmi_act && nmi_pend) begin
                  // Single level of nesting: NMI may preempt a maskable service only.
                  state <= REQ;
                  frame <= {1'b1, {VEC_W{1'b0}}};
                  nmi_r <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign core.INT       = int_r;
   assign core.NMI       = nmi_r;
   assign core.INTD      = intd_r;
   assign core.fsm_state = state;
   assign busy           = busy_r;
endmodule
